// File: rtl/cache_ri_miss_ctrl.sv
// Miss/refill engine for a 4-way cache: owns the ri_* tag-store port while it
// clears tags after reset, and while it evicts a dirty victim and refills a line.
module cache_ri_miss_ctrl #(
    parameter int ADDR_WIDTH = 7,
    parameter int LINE_WORDS = 4,
    parameter int OFS        = $clog2(LINE_WORDS),
    parameter int TAG_WIDTH  = 30 - OFS - ADDR_WIDTH
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        miss_req_i,
    output logic                        miss_ready_o,
    input  logic [31:0]                 miss_address_i,
    input  logic                        miss_isHaveFreeBlock_i,
    input  logic [1:0]                  miss_freeBlockNum_i,
    output logic                        miss_done_o,
    output logic                        sel_o,
    output logic [ADDR_WIDTH-1:0]       ri_readAddress_o,
    output logic [1:0]                  ri_readChannel_o,
    input  logic [31:0]                 ri_readData_i,
    output logic [ADDR_WIDTH-1:0]       ri_writeAddress_o,
    output logic [1:0]                  ri_writeChannel_o,
    output logic                        ri_writeEnable_o,
    output logic [31:0]                 ri_writeData_o,
    output logic [ADDR_WIDTH+1+OFS:0]   dr_address_o,
    input  logic [31:0]                 dr_data_i,
    output logic [ADDR_WIDTH+1+OFS:0]   dw_address_o,
    output logic [31:0]                 dw_data_o,
    output logic                        dw_writeEnable_o,
    output logic [31:0]                 mem_address_o,
    output logic                        mem_read_o,
    output logic                        mem_write_o,
    output logic [31:0]                 mem_writeData_o,
    input  logic [31:0]                 mem_readData_i,
    input  logic                        mem_waitRequest_i
);

    typedef enum logic [3:0] {
        INIT, IDLE, TAG_RD, TAG_CHK, WB_RD, WB_WR, RF, TAG_WR, DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  set_q, set_d;
    logic [1:0]             way_q, way_d;
    logic [OFS-1:0]         word_q, word_d;
    logic [1:0]             victim_q, victim_d;
    logic [TAG_WIDTH-1:0]   newTag_q, newTag_d;
    logic [TAG_WIDTH-1:0]   oldTag_q, oldTag_d;
    logic                   usedVictim_q, usedVictim_d;

    logic unusedBits;
    assign unusedBits = ^{ri_readData_i[31:TAG_WIDTH+2], miss_address_i[OFS+1:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= INIT;
            set_q        <= '0;
            way_q        <= '0;
            word_q       <= '0;
            victim_q     <= '0;
            newTag_q     <= '0;
            oldTag_q     <= '0;
            usedVictim_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            set_q        <= set_d;
            way_q        <= way_d;
            word_q       <= word_d;
            victim_q     <= victim_d;
            newTag_q     <= newTag_d;
            oldTag_q     <= oldTag_d;
            usedVictim_q <= usedVictim_d;
        end
    end

    // While reset is held every strobe is forced low and the tag port stays claimed.
    always_comb begin
        state_d           = state_q;
        set_d             = set_q;
        way_d             = way_q;
        word_d            = word_q;
        victim_d          = victim_q;
        newTag_d          = newTag_q;
        oldTag_d          = oldTag_q;
        usedVictim_d      = usedVictim_q;

        miss_ready_o      = 1'b0;
        miss_done_o       = 1'b0;
        sel_o             = 1'b0;
        ri_readAddress_o  = '0;
        ri_readChannel_o  = '0;
        ri_writeAddress_o = '0;
        ri_writeChannel_o = '0;
        ri_writeEnable_o  = 1'b0;
        ri_writeData_o    = '0;
        dr_address_o      = '0;
        dw_address_o      = '0;
        dw_data_o         = '0;
        dw_writeEnable_o  = 1'b0;
        mem_address_o     = '0;
        mem_read_o        = 1'b0;
        mem_write_o       = 1'b0;
        mem_writeData_o   = '0;

        if (rst_i) begin
            sel_o = 1'b1;
        end else begin
            case (state_q)
                INIT: begin
                    sel_o             = 1'b1;
                    ri_writeEnable_o  = 1'b1;
                    ri_writeAddress_o = set_q;
                    ri_writeChannel_o = way_q;
                    way_d             = way_q + 1'b1;
                    if (way_q == 2'd3) begin
                        set_d = set_q + 1'b1;
                        if (&set_q) begin
                            state_d = IDLE;
                        end
                    end
                end
                IDLE: begin
                    miss_ready_o = 1'b1;
                    if (miss_req_i) begin
                        set_d        = miss_address_i[OFS+ADDR_WIDTH+1:OFS+2];
                        newTag_d     = miss_address_i[31:32-TAG_WIDTH];
                        way_d        = miss_isHaveFreeBlock_i ? miss_freeBlockNum_i : victim_q;
                        usedVictim_d = ~miss_isHaveFreeBlock_i;
                        word_d       = '0;
                        state_d      = TAG_RD;
                    end
                end
                TAG_RD: begin
                    sel_o            = 1'b1;
                    ri_readAddress_o = set_q;
                    ri_readChannel_o = way_q;
                    state_d          = TAG_CHK;
                end
                TAG_CHK: begin
                    sel_o    = 1'b1;
                    oldTag_d = ri_readData_i[TAG_WIDTH-1:0];
                    word_d   = '0;
                    if (ri_readData_i[TAG_WIDTH] && ri_readData_i[TAG_WIDTH+1]) begin
                        state_d = WB_RD;
                    end else begin
                        state_d = RF;
                    end
                end
                WB_RD: begin
                    sel_o        = 1'b1;
                    dr_address_o = {set_q, way_q, word_q};
                    state_d      = WB_WR;
                end
                // The data RAM address is held here, so its registered output
                // stays stable for the whole (possibly stalled) memory write.
                WB_WR: begin
                    sel_o           = 1'b1;
                    dr_address_o    = {set_q, way_q, word_q};
                    mem_write_o     = 1'b1;
                    mem_address_o   = {oldTag_q, set_q, word_q, 2'b00};
                    mem_writeData_o = dr_data_i;
                    if (!mem_waitRequest_i) begin
                        if (&word_q) begin
                            word_d  = '0;
                            state_d = RF;
                        end else begin
                            word_d  = word_q + 1'b1;
                            state_d = WB_RD;
                        end
                    end
                end
                RF: begin
                    sel_o         = 1'b1;
                    mem_read_o    = 1'b1;
                    mem_address_o = {newTag_q, set_q, word_q, 2'b00};
                    if (!mem_waitRequest_i) begin
                        dw_writeEnable_o = 1'b1;
                        dw_address_o     = {set_q, way_q, word_q};
                        dw_data_o        = mem_readData_i;
                        if (&word_q) begin
                            word_d  = '0;
                            state_d = TAG_WR;
                        end else begin
                            word_d = word_q + 1'b1;
                        end
                    end
                end
                TAG_WR: begin
                    sel_o                           = 1'b1;
                    ri_writeEnable_o                = 1'b1;
                    ri_writeAddress_o               = set_q;
                    ri_writeChannel_o               = way_q;
                    ri_writeData_o[TAG_WIDTH]       = 1'b1;
                    ri_writeData_o[TAG_WIDTH-1:0]   = newTag_q;
                    state_d                         = DONE;
                end
                DONE: begin
                    miss_done_o = 1'b1;
                    if (usedVictim_q) begin
                        victim_d = victim_q + 1'b1;
                    end
                    state_d = IDLE;
                end
                default: begin
                    state_d = INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ri_miss_ctrl.sv
// Bench for cache_ri_miss_ctrl: models tag store, data RAM and a stalling memory,
// and scores memory, data-RAM and tag-write traffic against queued expectations.
module tb_cache_ri_miss_ctrl;

    localparam int AW  = 7;
    localparam int LW  = 4;
    localparam int OFS = 2;
    localparam int TW  = 21;
    localparam int DAW = AW + 2 + OFS;

    logic            clk = 1'b0;
    logic            rst;
    logic            missReq;
    logic            missReady;
    logic [31:0]     missAddr;
    logic            missFree;
    logic [1:0]      missFreeNum;
    logic            missDone;
    logic            sel;
    logic [AW-1:0]   riRdAddr;
    logic [1:0]      riRdCh;
    logic [31:0]     riRdData;
    logic [AW-1:0]   riWrAddr;
    logic [1:0]      riWrCh;
    logic            riWe;
    logic [31:0]     riWrData;
    logic [DAW-1:0]  drAddr;
    logic [31:0]     drData;
    logic [DAW-1:0]  dwAddr;
    logic [31:0]     dwData;
    logic            dwWe;
    logic [31:0]     memAddr;
    logic            memRd;
    logic            memWr;
    logic [31:0]     memWrData;
    logic [31:0]     memRdData;
    logic            memWait;

    always #5 clk = ~clk;

    cache_ri_miss_ctrl #(.ADDR_WIDTH(AW), .LINE_WORDS(LW)) dut (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .miss_req_i             (missReq),
        .miss_ready_o           (missReady),
        .miss_address_i         (missAddr),
        .miss_isHaveFreeBlock_i (missFree),
        .miss_freeBlockNum_i    (missFreeNum),
        .miss_done_o            (missDone),
        .sel_o                  (sel),
        .ri_readAddress_o       (riRdAddr),
        .ri_readChannel_o       (riRdCh),
        .ri_readData_i          (riRdData),
        .ri_writeAddress_o      (riWrAddr),
        .ri_writeChannel_o      (riWrCh),
        .ri_writeEnable_o       (riWe),
        .ri_writeData_o         (riWrData),
        .dr_address_o           (drAddr),
        .dr_data_i              (drData),
        .dw_address_o           (dwAddr),
        .dw_data_o              (dwData),
        .dw_writeEnable_o       (dwWe),
        .mem_address_o          (memAddr),
        .mem_read_o             (memRd),
        .mem_write_o            (memWr),
        .mem_writeData_o        (memWrData),
        .mem_readData_i         (memRdData),
        .mem_waitRequest_i      (memWait)
    );

    // Environment: tag store and data RAM with 1-cycle registered reads, plus poke ports.
    logic [31:0]    tagMem [0:4*(2**AW)-1];
    logic [31:0]    dram   [0:(2**DAW)-1];
    logic           tPokeEn, dPokeEn;
    logic [AW+1:0]  tPokeIdx;
    logic [DAW-1:0] dPokeAddr;
    logic [31:0]    tPokeData, dPokeData;

    always @(posedge clk) begin
        if (riWe)         tagMem[{riWrAddr, riWrCh}] <= riWrData;
        else if (tPokeEn) tagMem[tPokeIdx] <= tPokeData;
        riRdData <= tagMem[{riRdAddr, riRdCh}];
    end

    always @(posedge clk) begin
        if (dwWe)         dram[dwAddr] <= dwData;
        else if (dPokeEn) dram[dPokeAddr] <= dPokeData;
        drData <= dram[drAddr];
    end

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    int stallTarget;
    int stallCnt;
    assign memWait   = (memRd | memWr) && (stallCnt < stallTarget);
    assign memRdData = memWord(memAddr);

    always @(posedge clk) begin
        if (rst || !(memRd | memWr) || !memWait) stallCnt <= 0;
        else                                     stallCnt <= stallCnt + 1;
    end

    typedef struct packed { logic wr; logic [31:0] addr; logic [31:0] data; } memTxn_t;
    typedef struct packed { logic [DAW-1:0] addr; logic [31:0] data; } dwTxn_t;
    typedef struct packed { logic [AW-1:0] set; logic [1:0] way; logic [31:0] data; } tagTxn_t;

    memTxn_t memQ[$];
    dwTxn_t  dwQ[$];
    tagTxn_t tagQ[$];
    memTxn_t mE;
    dwTxn_t  dE;
    tagTxn_t tE;

    int vectors = 0;
    int miscompares = 0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Monitor: pops expectations as the DUT completes transfers.
    bit          inInit;
    logic        prevStall = 1'b0;
    logic [31:0] prevAddr, prevData;
    int          stableErr = 0;
    int          bothErr = 0;

    always @(negedge clk) begin
        if (rst) begin
            prevStall = 1'b0;
        end else begin
            if (memRd && memWr) bothErr++;
            if (prevStall && (memAddr !== prevAddr || (memWr && memWrData !== prevData))) stableErr++;
            prevStall = (memRd | memWr) && memWait;
            prevAddr  = memAddr;
            prevData  = memWrData;
            if ((memRd | memWr) && !memWait) begin
                if (memQ.size() == 0) checkOutput("memUnexpected", 1, 0);
                else begin
                    mE = memQ.pop_front();
                    checkOutput("memKind", memWr, mE.wr);
                    checkOutput("memAddr", memAddr, mE.addr);
                    if (mE.wr) checkOutput("memWrData", memWrData, mE.data);
                end
            end
            if (dwWe) begin
                if (dwQ.size() == 0) checkOutput("dwUnexpected", 1, 0);
                else begin
                    dE = dwQ.pop_front();
                    checkOutput("dwAddr", dwAddr, dE.addr);
                    checkOutput("dwData", dwData, dE.data);
                end
            end
            if (riWe && !inInit) begin
                if (tagQ.size() == 0) checkOutput("tagUnexpected", 1, 0);
                else begin
                    tE = tagQ.pop_front();
                    checkOutput("tagWrAddr", riWrAddr, tE.set);
                    checkOutput("tagWrWay", riWrCh, tE.way);
                    checkOutput("tagWrData", riWrData, tE.data);
                end
            end
        end
    end

    // Bench-side shadows of what tags and line data should be.
    logic [31:0] expTag  [0:4*(2**AW)-1];
    logic [31:0] expDram [0:(2**DAW)-1];
    logic [1:0]  victimModel;

    task automatic pokeTag(input logic [AW-1:0] s, input logic [1:0] w, input logic [31:0] d);
        tPokeEn = 1'b1; tPokeIdx = {s, w}; tPokeData = d; expTag[{s, w}] = d;
        @(negedge clk);
        tPokeEn = 1'b0;
    endtask

    task automatic pokeData(input logic [DAW-1:0] a, input logic [31:0] d);
        dPokeEn = 1'b1; dPokeAddr = a; dPokeData = d; expDram[a] = d;
        @(negedge clk);
        dPokeEn = 1'b0;
    endtask

    // Releases reset and follows the full tag-clearing sweep.
    task automatic initSweep(input string tag);
        int good = 0;
        inInit = 1'b1;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4 * (2**AW); i++) begin
            if (riWe === 1'b1 && riWrData === 32'd0 && sel === 1'b1 &&
                riWrAddr === AW'(i >> 2) && riWrCh === 2'(i)) good++;
            @(negedge clk);
        end
        checkOutput(tag, good, 4 * (2**AW));
        checkOutput("readyAfterInit", missReady, 1);
        checkOutput("selAfterInit", sel, 0);
        checkOutput("noWeAfterInit", riWe, 0);
        inInit = 1'b0;
        for (int i = 0; i < 4 * (2**AW); i++) expTag[i] = 32'd0;
        victimModel = 2'd0;
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input bit free, input logic [1:0] freeNum);
        int n = 0;
        logic [AW-1:0] s;
        logic [TW-1:0] nt;
        logic [1:0]    w;
        logic [31:0]   old;
        logic [31:0]   a;
        while (missReady !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("readyBeforeReq", missReady, 1);
        s   = addr[OFS+AW+1:OFS+2];
        nt  = addr[31:32-TW];
        w   = free ? freeNum : victimModel;
        old = expTag[{s, w}];
        if (old[TW] && old[TW+1]) begin
            for (int k = 0; k < LW; k++) begin
                a = {old[TW-1:0], s, 2'(k), 2'b00};
                memQ.push_back('{wr: 1'b1, addr: a, data: expDram[{s, w, 2'(k)}]});
            end
        end
        for (int k = 0; k < LW; k++) begin
            a = {nt, s, 2'(k), 2'b00};
            memQ.push_back('{wr: 1'b0, addr: a, data: 32'd0});
            dwQ.push_back('{addr: {s, w, 2'(k)}, data: memWord(a)});
            expDram[{s, w, 2'(k)}] = memWord(a);
        end
        expTag[{s, w}] = (32'd1 << TW) | 32'(nt);
        tagQ.push_back('{set: s, way: w, data: expTag[{s, w}]});
        if (!free) victimModel = victimModel + 2'd1;
        missReq = 1'b1; missAddr = addr; missFree = free; missFreeNum = freeNum;
        @(negedge clk);
        missReq = 1'b0;
        checkOutput("selBusy", sel, 1);
        checkOutput("readyBusy", missReady, 0);
    endtask

    task automatic waitDone(input string tag);
        int n = 0;
        while (missDone !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, missDone, 1);
        checkOutput("selAtDone", sel, 0);
        checkOutput("queuesDrained", memQ.size() + dwQ.size() + tagQ.size(), 0);
        @(negedge clk);
        checkOutput("doneIsPulse", missDone, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; missReq = 1'b0; missAddr = '0; missFree = 1'b0; missFreeNum = '0;
        tPokeEn = 1'b0; dPokeEn = 1'b0; tPokeIdx = '0; dPokeAddr = '0; tPokeData = '0; dPokeData = '0;
        stallTarget = 0; inInit = 1'b1; victimModel = 2'd0;
        repeat (3) @(negedge clk);
        checkOutput("rstSel", sel, 1);
        checkOutput("rstReady", missReady, 0);
        checkOutput("rstMemRd", memRd, 0);
        checkOutput("rstTagWe", riWe, 0);
        initSweep("initSweep");

        // Free way 2, invalid old tag: refill only.
        applyStimulus(32'h0000_1230, 1'b1, 2'd2);
        waitDone("doneFreeWay");

        // Dirty victim in way 0, memory stalling 3 cycles per word.
        pokeTag(7'h23, 2'd0, 32'h0060_0005);
        for (int k = 0; k < LW; k++) pokeData({7'h23, 2'd0, 2'(k)}, 32'hD00D_0000 + 32'(k));
        stallTarget = 3;
        applyStimulus(32'h0000_3A30, 1'b0, 2'd0);
        waitDone("doneWriteback");

        // Further no-free misses walk the victim counter 1,2,3,0.
        stallTarget = 1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(((32'h100 + 32'(i)) << 11) | ((32'h10 + 32'(i)) << 4) | 32'hC, 1'b0, 2'd3);
            waitDone("doneVictimWalk");
        end

        // Reset during the second refill word restarts the sweep.
        stallTarget = 2;
        applyStimulus(32'h0000_2400, 1'b1, 2'd1);
        begin
            int n = 0;
            while (dwQ.size() != LW - 1 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        checkOutput("reachedWord2", dwQ.size(), LW - 1);
        @(negedge clk);
        checkOutput("addrWord2", memAddr, 32'h0000_2404);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abortMemRd", memRd, 0);
        checkOutput("abortMemWr", memWr, 0);
        checkOutput("abortSel", sel, 1);
        memQ.delete(); dwQ.delete(); tagQ.delete();
        initSweep("initSweepAfterAbort");

        // Victim counter restarts at way 0 after reset.
        stallTarget = 0;
        applyStimulus(32'h0000_4560, 1'b0, 2'd2);
        waitDone("doneAfterAbort");

        checkOutput("neverReadAndWrite", bothErr, 0);
        checkOutput("stableDuringStall", stableErr, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
